// File: rtl/tron_grid_ctrl.sv
// tron_grid_ctrl: owner of the 64x48 playfield cell grid (2-bit owner codes).
// Sequences whole-grid clears, arbitrates atomic test-and-set claims from the
// two player controllers (round-robin on ties), and serves a one-cycle-latency
// display read port.
// Optional build macro: TRON_GRID_BORDER_EN -- clear sweep paints border cells
// with the wall code (3) instead of empty (0).
module tron_grid_ctrl #(
  parameter int H_CELLS = 64,
  parameter int V_CELLS = 48
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       clear_start,
  output logic       busy,
  output logic       clear_done,
  input  logic       req_p1,
  input  logic [5:0] x_p1,
  input  logic [5:0] y_p1,
  output logic       ack_p1,
  output logic       hit_p1,
  output logic [1:0] prev_p1,
  input  logic       req_p2,
  input  logic [5:0] x_p2,
  input  logic [5:0] y_p2,
  output logic       ack_p2,
  output logic       hit_p2,
  output logic [1:0] prev_p2,
  input  logic [5:0] disp_x,
  input  logic [5:0] disp_y,
  output logic [1:0] disp_owner
);

  localparam int          N_CELLS   = H_CELLS * V_CELLS;
  localparam logic [11:0] LAST_ADDR = 12'(N_CELLS - 1);
  localparam logic [5:0]  Y_LIM     = 6'(V_CELLS);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_WR, S_ACK} state_t;

  // Grid storage: address = {y, x}, valid only for y < V_CELLS.
  logic [1:0] grid_mem [0:N_CELLS-1];

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        gnt1_q, gnt1_d;
  logic        gnt2_q, gnt2_d;
  logic        last_p2_q, last_p2_d;
  logic        ack1_q, ack1_d;
  logic        ack2_q, ack2_d;
  logic        hit1_q, hit1_d;
  logic        hit2_q, hit2_d;
  logic [1:0]  prev1_q, prev1_d;
  logic [1:0]  prev2_q, prev2_d;
  logic        done_q, done_d;
  logic [5:0]  ax_q, ax_d;
  logic [5:0]  ay_q, ay_d;
  logic [1:0]  win_q, win_d;
  logic [1:0]  rd_data_q;
  logic [1:0]  disp_owner_q;

  logic        we;
  logic [11:0] waddr;
  logic [1:0]  wdata;
  logic [1:0]  clr_val;
  logic        oor;
  logic        hit_v;
  logic [1:0]  prev_v;

`ifdef TRON_GRID_BORDER_EN
  localparam logic [5:0] H_LAST = 6'(H_CELLS - 1);
  // Border cells of the sweep address get the wall code.
  always_comb begin
    clr_val = 2'd0;
    if (cnt_q[5:0] == 6'd0 || cnt_q[5:0] == H_LAST ||
        cnt_q[11:6] == 6'd0 || cnt_q[11:6] == Y_LIM - 6'd1)
      clr_val = 2'd3;
  end
`else
  assign clr_val = 2'd0;
`endif

  assign oor    = (ay_q >= Y_LIM);
  assign prev_v = oor ? 2'd3 : rd_data_q;
  assign hit_v  = oor | (rd_data_q != 2'd0) | (gnt1_q & gnt2_q);

  // Next-state, arbitration, sweep counter and write-port selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    gnt1_d    = gnt1_q;
    gnt2_d    = gnt2_q;
    last_p2_d = last_p2_q;
    ack1_d    = 1'b0;
    ack2_d    = 1'b0;
    hit1_d    = hit1_q;
    hit2_d    = hit2_q;
    prev1_d   = prev1_q;
    prev2_d   = prev2_q;
    done_d    = 1'b0;
    ax_d      = ax_q;
    ay_d      = ay_q;
    win_d     = win_q;
    we        = 1'b0;
    waddr     = cnt_q;
    wdata     = clr_val;
    case (state_q)
      S_CLEAR: begin
        we     = 1'b1;
        pend_d = 1'b0;
        if (clear_start) begin
          cnt_d = 12'd0;
        end else if (cnt_q == LAST_ADDR) begin
          cnt_d   = 12'd0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_IDLE: begin
        if (clear_start || pend_q) begin
          state_d = S_CLEAR;
          cnt_d   = 12'd0;
          pend_d  = 1'b0;
        end else if (req_p1 || req_p2) begin
          state_d = S_RD;
          gnt1_d  = 1'b0;
          gnt2_d  = 1'b0;
          if (req_p1 && req_p2) begin
            // Tie: the player not granted last tie wins.
            if (last_p2_q) begin
              gnt1_d    = 1'b1;
              win_d     = 2'd1;
              ax_d      = x_p1;
              ay_d      = y_p1;
              last_p2_d = 1'b0;
            end else begin
              gnt2_d    = 1'b1;
              win_d     = 2'd2;
              ax_d      = x_p2;
              ay_d      = y_p2;
              last_p2_d = 1'b1;
            end
            // Head-on collision: both players serviced in the same pass.
            if (x_p1 == x_p2 && y_p1 == y_p2) begin
              gnt1_d = 1'b1;
              gnt2_d = 1'b1;
            end
          end else if (req_p1) begin
            gnt1_d = 1'b1;
            win_d  = 2'd1;
            ax_d   = x_p1;
            ay_d   = y_p1;
          end else begin
            gnt2_d = 1'b1;
            win_d  = 2'd2;
            ax_d   = x_p2;
            ay_d   = y_p2;
          end
        end
      end
      S_RD: begin
        if (clear_start) pend_d = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        if (clear_start) pend_d = 1'b1;
        if (!oor && rd_data_q == 2'd0) begin
          we    = 1'b1;
          waddr = {ay_q, ax_q};
          wdata = win_q;
        end
        if (gnt1_q) begin
          hit1_d  = hit_v;
          prev1_d = prev_v;
        end
        if (gnt2_q) begin
          hit2_d  = hit_v;
          prev2_d = prev_v;
        end
        ack1_d  = gnt1_q;
        ack2_d  = gnt2_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (clear_start) pend_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q   <= S_CLEAR;
      cnt_q     <= 12'd0;
      pend_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      gnt2_q    <= 1'b0;
      last_p2_q <= 1'b1;
      ack1_q    <= 1'b0;
      ack2_q    <= 1'b0;
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      prev1_q   <= 2'd0;
      prev2_q   <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      gnt1_q    <= gnt1_d;
      gnt2_q    <= gnt2_d;
      last_p2_q <= last_p2_d;
      ack1_q    <= ack1_d;
      ack2_q    <= ack2_d;
      hit1_q    <= hit1_d;
      hit2_q    <= hit2_d;
      prev1_q   <= prev1_d;
      prev2_q   <= prev2_d;
      done_q    <= done_d;
    end
  end

  // Latched claim address and winning owner code (data, no reset).
  always_ff @(posedge clk_pix) begin
    ax_q  <= ax_d;
    ay_q  <= ay_d;
    win_q <= win_d;
  end

  // Single grid write port shared by the sweep and the claim write.
  always_ff @(posedge clk_pix) begin
    if (we) grid_mem[waddr] <= wdata;
  end

  // Claim read port: out-of-range rows never index the array.
  always_ff @(posedge clk_pix) begin
    if (ay_q < Y_LIM) rd_data_q <= grid_mem[{ay_q, ax_q}];
    else              rd_data_q <= 2'd0;
  end

  // Display read port: registered, returns pre-write contents on collision.
  always_ff @(posedge clk_pix) begin
    if (rst_pix)              disp_owner_q <= 2'd0;
    else if (disp_y < Y_LIM)  disp_owner_q <= grid_mem[{disp_y, disp_x}];
    else                      disp_owner_q <= 2'd0;
  end

  assign busy       = (state_q == S_CLEAR);
  assign clear_done = done_q;
  assign ack_p1     = ack1_q;
  assign hit_p1     = hit1_q;
  assign prev_p1    = prev1_q;
  assign ack_p2     = ack2_q;
  assign hit_p2     = hit2_q;
  assign prev_p2    = prev2_q;
  assign disp_owner = disp_owner_q;

endmodule

// File: tb/tb_tron_grid_ctrl.sv
// Testbench for tron_grid_ctrl: directed and randomized claims scored against
// a transaction-level grid model; a monitor checks acks and display reads.
module tb_tron_grid_ctrl;

  logic       clk_pix = 1'b0;
  logic       rst_pix = 1'b1;
  logic       clear_start = 1'b0;
  logic       busy, clear_done;
  logic       req_p1 = 1'b0, req_p2 = 1'b0;
  logic [5:0] x_p1 = '0, y_p1 = '0, x_p2 = '0, y_p2 = '0;
  logic       ack_p1, hit_p1, ack_p2, hit_p2;
  logic [1:0] prev_p1, prev_p2, disp_owner;
  logic [5:0] disp_x = '0, disp_y = '0;

  tron_grid_ctrl dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .clear_start(clear_start),
    .busy(busy), .clear_done(clear_done),
    .req_p1(req_p1), .x_p1(x_p1), .y_p1(y_p1),
    .ack_p1(ack_p1), .hit_p1(hit_p1), .prev_p1(prev_p1),
    .req_p2(req_p2), .x_p2(x_p2), .y_p2(y_p2),
    .ack_p2(ack_p2), .hit_p2(hit_p2), .prev_p2(prev_p2),
    .disp_x(disp_x), .disp_y(disp_y), .disp_owner(disp_owner)
  );

  always #5 clk_pix = ~clk_pix;

  int cyc = 0;
  always @(posedge clk_pix) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int hit; int prev; int cyc; } exp_t;
  typedef struct { int val; int cyc; } dexp_t;
  exp_t  q1[$];
  exp_t  q2[$];
  dexp_t dq[$];

  // Reference model: plain array of owner codes plus the tie-winner memory.
  int grid [0:3071];
  int last_win = 2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clr_cell(input int a);
`ifdef TRON_GRID_BORDER_EN
    int x, y;
    x = a % 64;
    y = a / 64;
    return (x == 0 || x == 63 || y == 0 || y == 47) ? 3 : 0;
`else
    return (a < 0) ? 3 : 0;
`endif
  endfunction

  function automatic void model_clear();
    for (int a = 0; a < 3072; a++) grid[a] = clr_cell(a);
  endfunction

  function automatic void model_one(input int x, input int y, input int who,
                                    output int hit, output int prev);
    if (y >= 48) begin
      hit  = 1;
      prev = 3;
    end else begin
      prev = grid[y * 64 + x];
      hit  = (prev != 0) ? 1 : 0;
      if (hit == 0) grid[y * 64 + x] = who;
    end
  endfunction

  // Compute expectations, issue request(s) in an IDLE cycle, wait for acks.
  task automatic claim(input bit d1, input int x1, input int y1,
                       input bit d2, input int x2, input int y2);
    exp_t e1, e2;
    int c, w, h, p, n;
    c = cyc;
    if (d1 && d2) begin
      w = (last_win == 2) ? 1 : 2;
      last_win = w;
      if (x1 == x2 && y1 == y2) begin
        p = (y1 >= 48) ? 3 : grid[y1 * 64 + x1];
        if (y1 < 48 && p == 0) grid[y1 * 64 + x1] = w;
        e1 = '{1, p, c + 3};
        e2 = '{1, p, c + 3};
      end else if (w == 1) begin
        model_one(x1, y1, 1, h, p); e1 = '{h, p, c + 3};
        model_one(x2, y2, 2, h, p); e2 = '{h, p, c + 7};
      end else begin
        model_one(x2, y2, 2, h, p); e2 = '{h, p, c + 3};
        model_one(x1, y1, 1, h, p); e1 = '{h, p, c + 7};
      end
      q1.push_back(e1);
      q2.push_back(e2);
    end else if (d1) begin
      model_one(x1, y1, 1, h, p);
      q1.push_back('{h, p, c + 3});
    end else begin
      model_one(x2, y2, 2, h, p);
      q2.push_back('{h, p, c + 3});
    end
    x_p1 = 6'(x1); y_p1 = 6'(y1);
    x_p2 = 6'(x2); y_p2 = 6'(y2);
    req_p1 = d1;
    req_p2 = d2;
    n = 0;
    while ((req_p1 || req_p2) && n < 40) begin
      @(negedge clk_pix);
      n++;
      if (ack_p1) req_p1 = 1'b0;
      if (ack_p2) req_p2 = 1'b0;
    end
    chk("claim_ack_timeout", (req_p1 || req_p2) ? 1 : 0, 0);
    req_p1 = 1'b0;
    req_p2 = 1'b0;
    @(negedge clk_pix);
  endtask

  // Called on a negedge inside the first sweep cycle.
  task automatic measure_sweep(input string tag);
    int n, dn;
    n = 0;
    dn = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk_pix);
      if (clear_done) dn++;
    end
    repeat (3) begin
      @(negedge clk_pix);
      if (clear_done) dn++;
    end
    chk({tag, "_busy_len"}, n, 3072);
    chk({tag, "_done_pulses"}, dn, 1);
    model_clear();
  endtask

  // Read every cell (plus two rows beyond the grid) via the display port.
  task automatic scan();
    for (int y = 0; y < 50; y++) begin
      for (int x = 0; x < 64; x++) begin
        disp_x = 6'(x);
        disp_y = 6'(y);
        dq.push_back('{(y < 48) ? grid[y * 64 + x] : 0, cyc + 1});
        @(negedge clk_pix);
      end
    end
    @(negedge clk_pix);
  endtask

  // Monitor: scores every ack and display read against the queued expectations.
  always @(negedge clk_pix) begin : monitor
    exp_t  e;
    dexp_t d;
    if (!rst_pix) begin
      if (ack_p1) begin
        if (q1.size() == 0) chk("ack_p1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          chk("hit_p1", int'(hit_p1), e.hit);
          chk("prev_p1", int'(prev_p1), e.prev);
          chk("ack_p1_cycle", cyc, e.cyc);
        end
      end
      if (ack_p2) begin
        if (q2.size() == 0) chk("ack_p2_unexpected", 1, 0);
        else begin
          e = q2.pop_front();
          chk("hit_p2", int'(hit_p2), e.hit);
          chk("prev_p2", int'(prev_p2), e.prev);
          chk("ack_p2_cycle", cyc, e.cyc);
        end
      end
      while (dq.size() > 0 && dq[0].cyc <= cyc) begin
        d = dq.pop_front();
        if (d.cyc == cyc) chk("disp_owner", int'(disp_owner), d.val);
        else chk("disp_stale", d.cyc, cyc);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, m, x1, y1, x2, y2, h, p;
    model_clear();
    rst_pix = 1'b1;
    repeat (3) @(negedge clk_pix);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ack_p1", int'(ack_p1), 0);
    chk("rst_ack_p2", int'(ack_p2), 0);
    chk("rst_hit_p1", int'(hit_p1), 0);
    chk("rst_prev_p2", int'(prev_p2), 0);
    chk("rst_clear_done", int'(clear_done), 0);
    chk("rst_disp_owner", int'(disp_owner), 0);
    rst_pix = 1'b0;
    measure_sweep("reset_sweep");
    scan();

    // Claim, re-claim, and opponent claim of the same cell.
    claim(1, 5, 24, 0, 0, 0);
    claim(1, 5, 24, 0, 0, 0);
    claim(0, 0, 0, 1, 5, 24);
    // Ties on different cells: P1 first, then P2 first on the repeat.
    claim(1, 10, 10, 1, 50, 10);
    claim(1, 11, 10, 1, 51, 10);
    // Head-on collision on one cell.
    claim(1, 30, 20, 1, 30, 20);
    // Out-of-range rows.
    claim(1, 7, 50, 0, 0, 0);
    claim(0, 0, 0, 1, 63, 63);
    scan();

    // clear_start during RD: claim completes, then a full sweep runs.
    model_one(40, 30, 1, h, p);
    q1.push_back('{h, p, cyc + 3});
    x_p1 = 6'd40; y_p1 = 6'd30; req_p1 = 1'b1;
    @(negedge clk_pix);
    clear_start = 1'b1;
    @(negedge clk_pix);
    clear_start = 1'b0;
    n = 0;
    while (req_p1 && n < 40) begin
      @(negedge clk_pix);
      n++;
      if (ack_p1) req_p1 = 1'b0;
    end
    chk("mid_clear_ack_timeout", int'(req_p1), 0);
    req_p1 = 1'b0;
    m = 0;
    while (!busy && m < 20) begin
      @(negedge clk_pix);
      m++;
    end
    chk("mid_clear_busy_delay", m, 2);
    measure_sweep("mid_clear_sweep");

    // clear_start in IDLE: busy on the very next cycle.
    @(negedge clk_pix);
    clear_start = 1'b1;
    @(negedge clk_pix);
    clear_start = 1'b0;
    chk("idle_clear_busy", int'(busy), 1);
    measure_sweep("idle_clear_sweep");

    // Randomized claims on a small window so collisions are frequent.
    for (int i = 0; i < 120; i++) begin
      m  = $urandom_range(0, 3);
      x1 = $urandom_range(0, 7);
      y1 = ($urandom_range(0, 9) == 0) ? $urandom_range(48, 63) : $urandom_range(0, 7);
      x2 = $urandom_range(0, 7);
      y2 = ($urandom_range(0, 9) == 0) ? $urandom_range(48, 63) : $urandom_range(0, 7);
      case (m)
        0: claim(1, x1, y1, 0, 0, 0);
        1: claim(0, 0, 0, 1, x2, y2);
        2: begin
          if (x1 == x2 && y1 == y2) x2 = (x2 + 1) % 8;
          claim(1, x1, y1, 1, x2, y2);
        end
        default: claim(1, x1, y1, 1, x1, y1);
      endcase
    end
    scan();

    repeat (5) @(negedge clk_pix);
    chk("q1_leftover", q1.size(), 0);
    chk("q2_leftover", q2.size(), 0);
    chk("dq_leftover", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
